// File: rtl/edram_bank_sequencer.sv
// edram_bank_sequencer: one-request-at-a-time eDRAM access sequencer with per-bank idle power gating.
// Define EDRAM_REFRESH_EN to build in the periodic refresh engine (REF_PRE/REF_ACT states).
module edram_bank_sequencer #(
  parameter int NUM_BANKS      = 16,
  parameter int BANK_ADDR_W    = 11,
  parameter int DATA_W         = 32,
  parameter int WAKE_CYCLES    = 4,
  parameter int IDLE_TIMEOUT   = 64,
  parameter int REFRESH_PERIOD = 512
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic                                     req_we,
  input  logic [$clog2(NUM_BANKS)+BANK_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]                        req_wdata,
  output logic                                     rsp_valid,
  output logic [DATA_W-1:0]                        rsp_rdata,
  output logic                                     rsp_err,
  output logic [NUM_BANKS-1:0]                     bank_sel,
  output logic [BANK_ADDR_W-1:0]                   bank_addr,
  output logic [DATA_W-1:0]                        bank_wdata,
  output logic                                     precharge_en,
  output logic                                     row_decode_en,
  output logic                                     col_decode_en,
  output logic                                     sense_amp_en,
  output logic                                     write_driver_en,
  input  logic [NUM_BANKS*DATA_W-1:0]              bank_rdata,
  output logic [NUM_BANKS-1:0]                     power_gate_en,
  output logic [NUM_BANKS-1:0]                     rbb_en,
  output logic [3:0]                               fsm_state
);

  localparam int BSEL_W = $clog2(NUM_BANKS);
  localparam int TW     = $clog2(IDLE_TIMEOUT + 1);
  localparam int WW     = $clog2(WAKE_CYCLES + 1);
  localparam logic [BSEL_W:0]    BANK_LIMIT = (BSEL_W + 1)'(NUM_BANKS);
  localparam logic [NUM_BANKS-1:0] SEL_ONE  = NUM_BANKS'(1);

  if (NUM_BANKS < 2 || NUM_BANKS > 64 || WAKE_CYCLES < 1 || IDLE_TIMEOUT < 1 ||
      REFRESH_PERIOD < 1) begin : g_param_check
    $error("edram_bank_sequencer: parameter out of range");
  end

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, outside reset and with no refresh pending.
  typedef enum logic [3:0] {
    S_IDLE, S_WAKE, S_PRE, S_ROW, S_COL, S_ACC, S_RESP, S_REF_PRE, S_REF_ACT
  } state_t;

  state_t               state;
  logic [BSEL_W-1:0]    req_bank;
  logic [BSEL_W-1:0]    bank_q;
  logic                 we_q;
  logic [WW-1:0]        wake_cnt;
  logic [NUM_BANKS-1:0] req_onehot;
  logic [NUM_BANKS-1:0] target_onehot;
  logic [NUM_BANKS-1:0] busy_mask;
  logic [NUM_BANKS-1:0] wake_mask;
  logic                 req_in_range;
  logic                 accept;
  logic                 target_gated;
  logic                 refresh_pending;
  logic [DATA_W-1:0]    acc_rdata;
  logic [TW-1:0]        idle_timer [NUM_BANKS];

  assign req_bank      = req_addr[BSEL_W+BANK_ADDR_W-1 -: BSEL_W];
  assign req_in_range  = {1'b0, req_bank} < BANK_LIMIT;
  // Out-of-range indices shift the one-hot off the end, so they select no bank.
  assign req_onehot    = SEL_ONE << req_bank;
  assign target_onehot = SEL_ONE << bank_q;
  assign target_gated  = |(power_gate_en & req_onehot);
  assign req_ready     = (state == S_IDLE) && !rst && !refresh_pending;
  assign accept        = req_valid && req_ready;
  assign wake_mask     = (accept && req_in_range && target_gated) ? req_onehot : '0;
  assign rbb_en        = power_gate_en;
  assign fsm_state     = state;

  always_comb begin
    busy_mask = accept ? req_onehot : '0;
    if (state == S_WAKE || state == S_PRE || state == S_ROW || state == S_COL ||
        state == S_ACC || state == S_RESP) begin
      busy_mask = busy_mask | target_onehot;
    end
  end

  always_comb begin
    acc_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == BSEL_W'(b)) acc_rdata = bank_rdata[b*DATA_W +: DATA_W];
    end
  end

`ifdef EDRAM_REFRESH_EN
  localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  logic [RW-1:0]          ref_cnt;
  logic [BANK_ADDR_W-1:0] ref_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt         <= '0;
      refresh_pending <= 1'b0;
      ref_row         <= '0;
    end else begin
      if (ref_cnt == RW'(REFRESH_PERIOD - 1)) ref_cnt <= '0;
      else                                    ref_cnt <= ref_cnt + 1'b1;
      // The FSM consumes (or skips) a pending refresh in its first IDLE cycle.
      if (ref_cnt == RW'(REFRESH_PERIOD - 1)) refresh_pending <= 1'b1;
      else if (state == S_IDLE)               refresh_pending <= 1'b0;
      if (state == S_REF_ACT) ref_row <= ref_row + 1'b1;
    end
  end
`else
  assign refresh_pending = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      bank_q          <= '0;
      we_q            <= 1'b0;
      wake_cnt        <= '0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      bank_sel        <= '0;
      bank_addr       <= '0;
      bank_wdata      <= '0;
      precharge_en    <= 1'b0;
      row_decode_en   <= 1'b0;
      col_decode_en   <= 1'b0;
      sense_amp_en    <= 1'b0;
      write_driver_en <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
`ifdef EDRAM_REFRESH_EN
          if (refresh_pending) begin
            if (|(~power_gate_en)) begin
              state        <= S_REF_PRE;
              precharge_en <= 1'b1;
              bank_sel     <= ~power_gate_en;
              bank_addr    <= ref_row;
            end
          end else
`endif
          if (accept) begin
            bank_q     <= req_bank;
            we_q       <= req_we;
            bank_addr  <= req_addr[BANK_ADDR_W-1:0];
            bank_wdata <= req_wdata;
            if (!req_in_range) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (target_gated) begin
              state    <= S_WAKE;
              wake_cnt <= WW'(WAKE_CYCLES - 1);
            end else begin
              state        <= S_PRE;
              precharge_en <= 1'b1;
              bank_sel     <= req_onehot;
            end
          end
        end
        S_WAKE: begin
          if (wake_cnt == '0) begin
            state        <= S_PRE;
            precharge_en <= 1'b1;
            bank_sel     <= target_onehot;
          end else begin
            wake_cnt <= wake_cnt - 1'b1;
          end
        end
        S_PRE: begin
          state         <= S_ROW;
          precharge_en  <= 1'b0;
          row_decode_en <= 1'b1;
        end
        S_ROW: begin
          state         <= S_COL;
          row_decode_en <= 1'b0;
          col_decode_en <= 1'b1;
        end
        S_COL: begin
          state           <= S_ACC;
          col_decode_en   <= 1'b0;
          write_driver_en <= we_q;
          sense_amp_en    <= !we_q;
        end
        S_ACC: begin
          state           <= S_RESP;
          sense_amp_en    <= 1'b0;
          write_driver_en <= 1'b0;
          bank_sel        <= '0;
          rsp_valid       <= 1'b1;
          rsp_err         <= 1'b0;
          rsp_rdata       <= we_q ? '0 : acc_rdata;
        end
        S_RESP: begin
          state   <= S_IDLE;
          rsp_err <= 1'b0;
        end
`ifdef EDRAM_REFRESH_EN
        S_REF_PRE: begin
          state         <= S_REF_ACT;
          precharge_en  <= 1'b0;
          row_decode_en <= 1'b1;
          sense_amp_en  <= 1'b1;
        end
        S_REF_ACT: begin
          state         <= S_IDLE;
          row_decode_en <= 1'b0;
          sense_amp_en  <= 1'b0;
          bank_sel      <= '0;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // A bank that is the target of the running sequence (or of this cycle's
  // handshake) is held awake; that is what lets a same-cycle request beat the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      power_gate_en <= '1;
      for (int b = 0; b < NUM_BANKS; b++) idle_timer[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (wake_mask[b]) begin
          power_gate_en[b] <= 1'b0;
          idle_timer[b]    <= '0;
        end else if (busy_mask[b]) begin
          idle_timer[b] <= '0;
        end else if (!power_gate_en[b]) begin
          if (idle_timer[b] == TW'(IDLE_TIMEOUT - 1)) begin
            power_gate_en[b] <= 1'b1;
            idle_timer[b]    <= '0;
          end else begin
            idle_timer[b] <= idle_timer[b] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_edram_bank_sequencer.sv
// tb_edram_bank_sequencer: directed vector table, reset/timeout corner sequences and
// randomized requests checked against a timestamp-based power/latency model.
module tb_edram_bank_sequencer;

  localparam int NB    = 12;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int WAKE  = 4;
  localparam int IDLE  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [4+AW-1:0]   req_addr;
  logic [DW-1:0]     req_wdata;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [NB-1:0]     bank_sel;
  logic [AW-1:0]     bank_addr;
  logic [DW-1:0]     bank_wdata;
  logic              precharge_en, row_decode_en, col_decode_en, sense_amp_en, write_driver_en;
  logic [NB*DW-1:0]  bank_rdata;
  logic [NB-1:0]     power_gate_en;
  logic [NB-1:0]     rbb_en;
  logic [3:0]        fsm_state;
  logic [4:0]        strobes;

  edram_bank_sequencer #(
    .NUM_BANKS(NB), .BANK_ADDR_W(AW), .DATA_W(DW), .WAKE_CYCLES(WAKE),
    .IDLE_TIMEOUT(IDLE), .REFRESH_PERIOD(512)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .bank_sel(bank_sel), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .precharge_en(precharge_en), .row_decode_en(row_decode_en), .col_decode_en(col_decode_en),
    .sense_amp_en(sense_amp_en), .write_driver_en(write_driver_en), .bank_rdata(bank_rdata),
    .power_gate_en(power_gate_en), .rbb_en(rbb_en), .fsm_state(fsm_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign strobes = {precharge_en, row_decode_en, col_decode_en, sense_amp_en, write_driver_en};

  logic [DW-1:0] bank_val [NB];
  always_comb begin
    bank_rdata = '0;
    for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = bank_val[b];
  end

  // ---------------- reference model ----------------
  // A bank is awake if it was ever woken and fewer than IDLE idle cycles have
  // passed since the last cycle it was busy (its response cycle).
  bit ungated   [NB];
  int last_busy [NB];
  logic [DW:0] exp_q [$];

  function automatic logic [NB-1:0] model_gates(input int c);
    logic [NB-1:0] g;
    for (int b = 0; b < NB; b++) g[b] = !ungated[b] || (c > last_busy[b] + IDLE);
    return g;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      ungated[b]   = 1'b0;
      last_busy[b] = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_gates();
    logic [NB-1:0] g;
    g = model_gates(cyc);
    check("power_gate_en", 64'(power_gate_en), 64'(g));
    check("rbb_en", 64'(rbb_en), 64'(g));
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) begin
      @(negedge clk);
      check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      check_gates();
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input int bank, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int exp_lat, input logic exp_err,
                        input logic [DW-1:0] exp_rdata);
    int t, waited, phase;
    logic [NB-1:0] oh;
    logic [4:0] exp_strobe;
    logic [DW:0] exp_rsp;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", 64'(req_ready), 64'd1);
    if (!req_ready) return;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = {4'(bank), addr};
    req_wdata = wdata;
    t = cyc;
    exp_q.push_back({exp_err, exp_rdata});
    if (!exp_err) begin
      ungated[bank]   = 1'b1;
      last_busy[bank] = t + exp_lat;
    end
    oh = '0;
    if (bank < NB) oh[bank] = 1'b1;
    for (int k = 1; k <= exp_lat; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 15'($urandom);
      req_wdata = $urandom;
      phase = exp_err ? 0 : k - (exp_lat - 5);
      case (phase)
        1:       exp_strobe = 5'b10000;
        2:       exp_strobe = 5'b01000;
        3:       exp_strobe = 5'b00100;
        4:       exp_strobe = we ? 5'b00001 : 5'b00010;
        default: exp_strobe = 5'b00000;
      endcase
      check("strobes", 64'(strobes), 64'(exp_strobe));
      check("bank_sel", 64'(bank_sel), (phase >= 1 && phase <= 4) ? 64'(oh) : 64'd0);
      if (phase == 1) begin
        check("bank_addr", 64'(bank_addr), 64'(addr));
        check("bank_wdata", 64'(bank_wdata), 64'(wdata));
      end
      check("rsp_valid", 64'(rsp_valid), 64'(k == exp_lat));
      check_gates();
      if (k == exp_lat) begin
        exp_rsp = exp_q.pop_front();
        check("rsp_err_rdata", 64'({rsp_err, rsp_rdata}), 64'(exp_rsp));
      end
    end
    @(negedge clk);
    check("rsp_done_ready", 64'({rsp_valid, req_ready}), 64'b01);
    check("post_strobes", 64'({strobes, bank_sel}), 64'd0);
    check_gates();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          we;
    int            bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_lat;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, bank, lat;
    logic we, err;
    logic [NB-1:0] g;
    logic [DW-1:0] rd;

    vecs[0] = '{1'b0, 3,  11'h005, 32'h0,        9, 1'b0, 32'hC0DE_0003};
    vecs[1] = '{1'b1, 3,  11'h7FF, 32'hDEADBEEF, 5, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 3,  11'h005, 32'h0,        5, 1'b0, 32'hC0DE_0003};
    vecs[3] = '{1'b0, 13, 11'h0AA, 32'h0,        1, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 15, 11'h155, 32'h1234_5678, 1, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 11, 11'h3C3, 32'hA5A5_0F0F, 9, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 0,  11'h000, 32'h0,        9, 1'b0, 32'hC0DE_0000};
    vecs[7] = '{1'b0, 11, 11'h3C3, 32'h0,        5, 1'b0, 32'hC0DE_000B};
    vecs[8] = '{1'b0, 2,  11'h001, 32'h0,        9, 1'b0, 32'hC0DE_0002};

    for (int b = 0; b < NB; b++) bank_val[b] = 32'hC0DE_0000 | 32'(b);
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_power_gate", 64'(power_gate_en), 64'hFFF);
    check("reset_rbb", 64'(rbb_en), 64'hFFF);
    check("reset_ready", 64'(req_ready), 64'd1);
    check("reset_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    check("reset_strobes_sel", 64'({strobes, bank_sel}), 64'd0);
    check("reset_addr_wdata", 64'({bank_addr, bank_wdata}), 64'd0);

    for (int i = 0; i < 9; i++)
      do_req(vecs[i].we, vecs[i].bank, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_rdata);

    // Reset while a read to awake bank 2 is in COL.
    req_valid = 1'b1; req_we = 1'b0; req_addr = {4'd2, 11'h123};
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_before_rst", 64'(strobes), 64'b10000);
    @(negedge clk);
    @(negedge clk);
    check("col_before_rst", 64'(strobes), 64'b00100);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    check("rst_strobes_sel", 64'({strobes, bank_sel}), 64'd0);
    check("rst_addr_wdata", 64'({bank_addr, bank_wdata}), 64'd0);
    check("rst_gates", 64'({power_gate_en, rbb_en}), 64'hFF_FFFF);
    check("rst_ready_low", 64'(req_ready), 64'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("after_rst_ready", 64'(req_ready), 64'd1);
    idle_until(cyc + 6);

    // Timeout race: a request in the timeout cycle keeps the bank awake.
    do_req(1'b0, 3, 11'h010, 32'h0, 9, 1'b0, 32'hC0DE_0003);
    idle_until(last_busy[3] + IDLE);
    check("pg3_in_timeout_cycle", 64'(power_gate_en[3]), 64'd0);
    do_req(1'b0, 3, 11'h011, 32'h0, 5, 1'b0, 32'hC0DE_0003);
    idle_until(last_busy[3] + IDLE);
    check("pg3_before_timeout", 64'(power_gate_en[3]), 64'd0);
    @(negedge clk);
    check("pg3_after_timeout", 64'({power_gate_en[3], rbb_en[3]}), 64'b11);
    do_req(1'b1, 3, 11'h012, 32'h5555_AAAA, 9, 1'b0, 32'h0);

    // Randomized requests against the model.
    for (int i = 0; i < 80; i++) begin
      for (int b = 0; b < NB; b++) bank_val[b] = $urandom;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(55, 75) : $urandom_range(0, 2);
      idle_until(cyc + gap);
      bank = $urandom_range(0, 15);
      we   = 1'($urandom_range(0, 1));
      err  = (bank >= NB);
      g    = model_gates(cyc);
      lat  = err ? 1 : ((g[bank % NB]) ? 5 + WAKE : 5);
      rd   = (err || we) ? 32'h0 : bank_val[bank % NB];
      do_req(we, bank, 11'($urandom), $urandom, lat, err, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
